// File: rtl/sd_pkg.sv
// sd_pkg: shared types and constants for the SD SPI-mode command engine.
//   - sd_state_e   : command FSM states
//   - frame sizes, R1 constants
//   - build_frame(): assembles the 48-bit command frame
package sd_pkg;

  localparam int CMD_FRAME_BITS = 48;
  localparam int R1_BITS        = 8;

  localparam logic [7:0] R1_IDLE = 8'h01;
  localparam logic [7:0] R1_NONE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RESP,
    ST_READ,
    ST_DONE
  } sd_state_e;

  // Start bit 0, transmission bit 1, index, argument, CRC7, end bit 1.
  function automatic logic [CMD_FRAME_BITS-1:0] build_frame(
    input logic [5:0]  idx,
    input logic [31:0] arg,
    input logic [6:0]  crc
  );
    return {1'b0, 1'b1, idx, arg, crc, 1'b1};
  endfunction

endpackage

// File: rtl/sd_edge_detect.sv
// sd_edge_detect: brings the divided SD clock into the clk domain and turns
// it into single-cycle rise/fall enables.
// Ports:
//   clk_i, reset_i  system clock, synchronous active-high reset
//   sd_clk_i        divided SD clock (asynchronous to use here)
//   rise_o, fall_o  one-cycle pulses on the synchronized edges
//   level_o         delayed level; drives the SCK pin so the pin edge lands
//                   on the same clock edge at which the pulse is acted upon
module sd_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sd_clk_i,
  output logic rise_o,
  output logic fall_o,
  output logic level_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   d_q;
  logic                   sync_w;

  assign sync_w = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
      d_q    <= 1'b0;
    end else begin
      sync_q[0] <= sd_clk_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      d_q <= sync_w;
    end
  end

  assign rise_o  = sync_w & ~d_q;
  assign fall_o  = ~sync_w & d_q;
  assign level_o = d_q;

endmodule

// File: rtl/sd_spi_cmd.sv
// sd_spi_cmd: sends one 48-bit SD SPI-mode command MSB-first on MOSI, then
// polls MISO for the R1 response byte. Everything runs on clk; the divided
// SD clock only qualifies edges.
// Ports:
//   clk, reset                   system clock, sync active-high reset
//   sd_clk_in                    divided SD clock
//   start, cmd_index/arg/crc     request from init FSM (sampled in IDLE)
//   busy, done, timeout, resp    status / R1 result (valid with done)
//   sclk, cs_n, mosi, miso       card pins
module sd_spi_cmd
  import sd_pkg::*;
#(
  parameter int NCR_BYTES   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_clk_in,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  resp,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso
);

  localparam int POLL_W = $clog2(NCR_BYTES*8 + 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(NCR_BYTES*8 - 1);

  logic rise_w, fall_w;

  sd_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
    .clk_i   (clk),
    .reset_i (reset),
    .sd_clk_i(sd_clk_in),
    .rise_o  (rise_w),
    .fall_o  (fall_w),
    .level_o (sclk)
  );

  sd_state_e                 state_q, state_d;
  logic [CMD_FRAME_BITS-1:0] frame_q, frame_d;
  logic [5:0]                bit_cnt_q, bit_cnt_d;
  logic [POLL_W-1:0]         poll_cnt_q, poll_cnt_d;
  logic [3:0]                rd_cnt_q, rd_cnt_d;
  logic [7:0]                resp_q, resp_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      timeout_q, timeout_d;
  logic                      cs_n_q, cs_n_d;
  logic                      mosi_q, mosi_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      poll_cnt_q <= '0;
      rd_cnt_q   <= '0;
      resp_q     <= R1_NONE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      resp_q     <= resp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    poll_cnt_d = poll_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    resp_d     = resp_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timeout_d  = timeout_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;

    unique case (state_q)
      ST_IDLE: begin
        mosi_d = 1'b1;
        if (start) begin
          frame_d   = build_frame(cmd_index, cmd_arg, cmd_crc);
          busy_d    = 1'b1;
          cs_n_d    = 1'b0;
          bit_cnt_d = '0;
          timeout_d = 1'b0;
          state_d   = ST_SEND;
        end
      end
      // MOSI only moves on falls, so it is stable at every SCK rise.
      ST_SEND: begin
        if (fall_w) begin
          if (bit_cnt_q != 6'(CMD_FRAME_BITS)) begin
            mosi_d    = frame_q[CMD_FRAME_BITS-1];
            frame_d   = {frame_q[CMD_FRAME_BITS-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 6'd1;
          end else begin
            mosi_d     = 1'b1;
            poll_cnt_d = '0;
            state_d    = ST_WAIT_RESP;
          end
        end
      end
      // A 0 on MISO is the R1 start bit (R1 MSB is always 0).
      ST_WAIT_RESP: begin
        if (rise_w) begin
          if (!miso) begin
            resp_d   = {resp_q[6:0], 1'b0};
            rd_cnt_d = 4'd1;
            state_d  = ST_READ;
          end else begin
            poll_cnt_d = poll_cnt_q + 1'b1;
            if (poll_cnt_q == POLL_LAST) begin
              resp_d    = R1_NONE;
              timeout_d = 1'b1;
              state_d   = ST_DONE;
            end
          end
        end
      end
      ST_READ: begin
        if (rise_w) begin
          resp_d   = {resp_q[6:0], miso};
          rd_cnt_d = rd_cnt_q + 4'd1;
          if (rd_cnt_q == 4'(R1_BITS - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cs_n_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign resp    = resp_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;

endmodule

// File: doc/sd_spi_cmd.md
Name: sd_spi_cmd

Overview:
- Downstream consumer of the SD divided clock (sd_clk from the SD clock divider).
- Sends one 48-bit SD SPI-mode command frame MSB-first on MOSI, then polls MISO for the R1 response byte.
- All logic runs on the system clock `clk`. The divided clock is used only as an edge-qualified enable, never as a clock.
- Sits between the SD init/control FSM (start/command inputs) and the card pins.

Parameters:
- NCR_BYTES, 8, max response bytes polled after frame before timeout (poll limit = NCR_BYTES*8 SCK rising edges).
- SYNC_STAGES, 2, synchronizer depth on sd_clk_in.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- sd_clk_in  in  1  divided SD clock from divider.
- start  in  1  one-cycle request; sampled only in IDLE.
- cmd_index  in  6  SD command index.
- cmd_arg  in  32  command argument.
- cmd_crc  in  7  CRC7 of frame.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at transaction end.
- timeout  out  1  valid with done; 1 = no response start bit seen.
- resp  out  8  R1 byte, valid with done, held until next start.
- sclk  out  1  SD SCK pin.
- cs_n  out  1  card select, active low.
- mosi  out  1  data to card.
- miso  in  1  data from card.

Behaviour:
- Reset values: busy=0, done=0, timeout=0, resp=8'hFF, sclk=0, cs_n=1, mosi=1, state=IDLE, counters=0.
- Reset is honoured in any state. An in-flight transaction aborts; cs_n=1 on the cycle after reset is asserted.
- Edge detection:
  - sd_clk_in passes through SYNC_STAGES flops, then one delay flop d.
  - rise = sync & ~d; fall = ~sync & d.
  - sclk is driven from d, so pin transitions coincide with the cycle the pulse acts.
- Frame: {1'b0, 1'b1, cmd_index, cmd_arg, cmd_crc, 1'b1}, 48 bits, latched on start.
- States:
  - IDLE: start=1 → latch frame, busy=1, cs_n=0, bit_cnt=0 → SEND. start=0 → stay; mosi=1.
  - SEND: on fall with bit_cnt<48 → mosi=frame[47], shift left, bit_cnt+1. On fall with bit_cnt==48 → mosi=1, poll_cnt=0 → WAIT_RESP. rise is ignored.
  - WAIT_RESP: on rise sample miso.
    - miso=0 → resp shift-in 0, rd_cnt=1 → READ.
    - Otherwise poll_cnt+1. If poll_cnt reaches NCR_BYTES*8 → resp=8'hFF, timeout=1 → DONE.
  - READ: on rise shift miso into resp LSB, rd_cnt+1. At rd_cnt==8 → DONE.
  - DONE: done=1 for exactly one cycle, busy=0, cs_n=1 → IDLE.
- Handshake rules:
  - start while busy is ignored; inputs are not re-latched.
  - start may be asserted in the cycle DONE returns to IDLE. It is accepted on the next IDLE cycle only.
- Simultaneous rise/fall cannot occur, since each is a single-cycle pulse and the two are mutually exclusive.
- No sd_clk_in edges: FSM holds its state indefinitely. There is no system-clock watchdog.
- mosi changes only on fall pulses (or on entry/exit of IDLE). It is stable across every rise.
- timeout clears on the next accepted start.

Decomposition:
- sd_pkg:
  - state enum (IDLE, SEND, WAIT_RESP, READ, DONE).
  - CMD_FRAME_BITS=48, R1_BITS=8.
  - R1_IDLE=8'h01, R1_NONE=8'hFF.
  - Frame-build function.
- Sub-module sd_edge_detect: synchronizer, delay flop, rise/fall pulses, registered level for sclk. Parameter SYNC_STAGES.

Test Plan (bench drives sd_clk_in with a 16-cycle period for speed):
- CMD0: cmd_index=0, arg=0, crc=7'h4A; miso returns FF, FF, then 01 → MOSI carries 48'h40_0000_0000_95 MSB-first, sampled on sclk rise. resp=8'h01, timeout=0, done pulse width 1, cs_n low throughout.
- Timeout: CMD8 (index 8, arg 32'h1AA, crc 7'h43), miso held 1 → done after exactly 64 rise pulses post-frame, timeout=1, resp=8'hFF.
- Busy start: second start pulse during SEND with different cmd_index → frame unchanged, single done.
- Reset mid-SEND: assert reset after 20 bits → next cycle cs_n=1, mosi=1, busy=0, resp=8'hFF. A new start then sends a full clean frame.
- Stalled clock: freeze sd_clk_in mid-SEND for 1000 cycles → mosi, state and bit count hold. Resume → frame completes correctly.
- Back-to-back: start asserted in the IDLE cycle right after done → second transaction accepted with no lost or duplicated bits.
